// File: rtl/riscv_test_ctrl.sv
// riscv_test_ctrl
// Test controller that sits beside the single-cycle RISC-V core. It holds the
// core in reset for RST_HOLD_CYCLES edges, then counts cycles and retired
// instructions. It also snoops data-memory writes to the riscv-tests
// "tohost" word and reports PASS, FAIL (with test number) or TIMEOUT.
//
// Ports:
//   clk, rst          system clock (rising edge), async active-high reset
//   mem_we            core data-memory write enable
//   mem_addr          core data-memory byte address       [XLEN-1:0]
//   mem_wdata         core data-memory write data         [XLEN-1:0]
//   retire_valid      one instruction retired this cycle
//   core_rst          active-high reset to the core (synchronous deassert)
//   running           controller is in RUN
//   done              terminal state reached (sticky)
//   pass              PASS reached (sticky)
//   timeout           TIMEOUT reached (sticky)
//   fail_code         failing test number, 0 unless FAIL  [XLEN-2:0]
//   cycle_count       RUN cycles elapsed                  [CNT_W-1:0]
//   instret_count     instructions retired in RUN         [CNT_W-1:0]

module riscv_test_ctrl #(
  parameter int              XLEN            = 32,
  parameter int              CNT_W           = 32,
  parameter int              RST_HOLD_CYCLES = 4,
  parameter int              TIMEOUT_CYCLES  = 200,
  parameter logic [XLEN-1:0] TOHOST_ADDR     = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  input  logic             retire_valid,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-2:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  // Last RUN cycle value before the watchdog fires; unused when disabled.
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  instret_count_q, instret_count_d;
  logic [XLEN-2:0]   fail_code_q, fail_code_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;

  logic tohost_hit;
  logic tohost_term;

  assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
  // Even data words are syscall/print requests, not terminations.
  assign tohost_term = tohost_hit && mem_wdata[0];

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;
    fail_code_d     = fail_code_q;

    unique case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // Saturating counters: add one only while not all-ones.
        cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, ~&cycle_count_q};
        if (retire_valid) begin
          instret_count_d = instret_count_q + {{(CNT_W-1){1'b0}}, ~&instret_count_q};
        end

        // A terminating tohost write takes priority over watchdog expiry.
        if (tohost_term) begin
          if (mem_wdata == XLEN'(1)) begin
            state_d = S_PASS;
          end else begin
            state_d     = S_FAIL;
            fail_code_d = mem_wdata[XLEN-1:1];
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_count_q == TO_LAST)) begin
          state_d = S_TIMEOUT;
        end
      end

      default: begin
        // Terminal states are sticky until rst.
      end
    endcase

    // Outputs are decoded from the next state so they register on the same
    // edge as the transition.
    core_rst_d = (state_d == S_HOLD);
    running_d  = (state_d == S_RUN);
    done_d     = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
    pass_d     = (state_d == S_PASS);
    timeout_d  = (state_d == S_TIMEOUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_HOLD;
      hold_cnt_q      <= '0;
      cycle_count_q   <= '0;
      instret_count_q <= '0;
      fail_code_q     <= '0;
      core_rst_q      <= 1'b1;
      running_q       <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
      fail_code_q     <= fail_code_d;
      core_rst_q      <= core_rst_d;
      running_q       <= running_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      timeout_q       <= timeout_d;
    end
  end

  assign core_rst      = core_rst_q;
  assign running       = running_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Testbench for riscv_test_ctrl. Three instances share clock, reset and bus
// stimulus: [0] default watchdog (200), [1] watchdog 50, [2] watchdog off.
// Expected terminal results are queued when the terminating stimulus is
// driven and compared when the instance raises done.

module tb_riscv_test_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        retire_valid = 1'b0;

  logic [2:0]  core_rst, running, done, pass, timeout;
  logic [30:0] fail_code [3];
  logic [31:0] cycle_count [3];
  logic [31:0] instret_count [3];

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] cycles;
    logic [31:0] instret;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_test_ctrl #(.TIMEOUT_CYCLES(200)) dut0 (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire_valid(retire_valid),
    .core_rst(core_rst[0]), .running(running[0]), .done(done[0]),
    .pass(pass[0]), .timeout(timeout[0]), .fail_code(fail_code[0]),
    .cycle_count(cycle_count[0]), .instret_count(instret_count[0]));

  riscv_test_ctrl #(.TIMEOUT_CYCLES(50)) dut1 (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire_valid(retire_valid),
    .core_rst(core_rst[1]), .running(running[1]), .done(done[1]),
    .pass(pass[1]), .timeout(timeout[1]), .fail_code(fail_code[1]),
    .cycle_count(cycle_count[1]), .instret_count(instret_count[1]));

  riscv_test_ctrl #(.TIMEOUT_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .retire_valid(retire_valid),
    .core_rst(core_rst[2]), .running(running[2]), .done(done[2]),
    .pass(pass[2]), .timeout(timeout[2]), .fail_code(fail_code[2]),
    .cycle_count(cycle_count[2]), .instret_count(instret_count[2]));

  // Advance one edge; inputs driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    retire_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_we    = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
  endtask

  // Reset everything and return at RUN cycle 0 (count 0).
  task automatic bring_up();
    int budget;
    bus_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    budget = 0;
    while (!running[0] && budget < 10) begin
      step();
      budget++;
    end
    n_tests++;
    if (running[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bring_up: running=%b required 1 within 10 edges", running[0]);
    end
  endtask

  // Wait (bounded) for done on instance idx, then pop and compare.
  task automatic check_result(input int idx, input string name);
    int   budget;
    exp_t e;
    budget = 0;
    while (!done[idx] && budget < 100) begin
      step();
      budget++;
    end
    n_tests++;
    if (done[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: got %b required 1 (watchdog of bench expired)", name, done[idx]);
    end
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: queue empty, required one expected entry", name);
      return;
    end
    e = sb_q.pop_front();
    n_tests++;
    if (pass[idx] !== e.pass) begin
      n_fail++;
      $display("FAIL %s pass: got %b required %b", name, pass[idx], e.pass);
    end
    n_tests++;
    if (timeout[idx] !== e.timeout) begin
      n_fail++;
      $display("FAIL %s timeout: got %b required %b", name, timeout[idx], e.timeout);
    end
    n_tests++;
    if (fail_code[idx] !== e.fail_code) begin
      n_fail++;
      $display("FAIL %s fail_code: got %0d required %0d", name, fail_code[idx], e.fail_code);
    end
    n_tests++;
    if (cycle_count[idx] !== e.cycles) begin
      n_fail++;
      $display("FAIL %s cycle_count: got %0d required %0d", name, cycle_count[idx], e.cycles);
    end
    n_tests++;
    if (instret_count[idx] !== e.instret) begin
      n_fail++;
      $display("FAIL %s instret_count: got %0d required %0d", name, instret_count[idx], e.instret);
    end
    n_tests++;
    if (running[idx] !== 1'b0 || core_rst[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s running/core_rst: got %b/%b required 0/0", name, running[idx], core_rst[idx]);
    end
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      // Bus activity during reset must be ignored.
      bus_write(TOHOST, 32'h1);
      retire_valid = 1'b1;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (core_rst[i] !== 1'b1 || running[i] !== 1'b0 || done[i] !== 1'b0 ||
          pass[i] !== 1'b0 || timeout[i] !== 1'b0 || fail_code[i] !== '0 ||
          cycle_count[i] !== '0 || instret_count[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_values[%0d]: got rst=%b run=%b done=%b pass=%b to=%b fc=%0d cyc=%0d ins=%0d required 1 0 0 0 0 0 0 0",
                 i, core_rst[i], running[i], done[i], pass[i], timeout[i],
                 fail_code[i], cycle_count[i], instret_count[i]);
      end
    end
    // Bus activity in HOLD must also be ignored.
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      n_tests++;
      if (e < 4) begin
        if (core_rst[0] !== 1'b1 || running[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_edge%0d: core_rst=%b running=%b required 1 0", e, core_rst[0], running[0]);
        end
      end else begin
        if (core_rst[0] !== 1'b0 || running[0] !== 1'b1 || cycle_count[0] !== 32'd0 ||
            instret_count[0] !== 32'd0 || done[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_release: core_rst=%b running=%b cyc=%0d ins=%0d done=%b required 0 1 0 0 0",
                   core_rst[0], running[0], cycle_count[0], instret_count[0], done[0]);
        end
      end
    end
    bus_idle();
  endtask

  task automatic test_pass();
    logic [31:0] cyc_frz, ins_frz;
    bring_up();
    for (int k = 0; k <= 12; k++) begin
      retire_valid = (k < 10);
      if (k == 12) begin
        bus_write(TOHOST, 32'h1);
        sb_q.push_back('{pass: 1'b1, timeout: 1'b0, fail_code: 31'd0, cycles: 32'd13, instret: 32'd10});
      end
      step();
      if (k == 11) begin
        n_tests++;
        if (done[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_early_done: got %b required 0", done[0]);
        end
      end
    end
    bus_idle();
    check_result(0, "pass");
    cyc_frz = 32'd13;
    ins_frz = 32'd10;
    for (int k = 0; k < 5; k++) begin
      retire_valid = 1'b1;
      bus_write(TOHOST, 32'h7);
      step();
    end
    bus_idle();
    n_tests++;
    if (cycle_count[0] !== cyc_frz || instret_count[0] !== ins_frz ||
        pass[0] !== 1'b1 || fail_code[0] !== '0) begin
      n_fail++;
      $display("FAIL pass_frozen: cyc=%0d ins=%0d pass=%b fc=%0d required %0d %0d 1 0",
               cycle_count[0], instret_count[0], pass[0], fail_code[0], cyc_frz, ins_frz);
    end
  endtask

  task automatic test_fail();
    bring_up();
    bus_write(TOHOST, 32'h8);
    step();
    n_tests++;
    if (done[0] !== 1'b0 || running[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL even_write_ignored: done=%b running=%b required 0 1", done[0], running[0]);
    end
    bus_write(TOHOST, 32'h7);
    sb_q.push_back('{pass: 1'b0, timeout: 1'b0, fail_code: 31'd3, cycles: 32'd2, instret: 32'd0});
    step();
    bus_idle();
    check_result(0, "fail");
    bus_write(TOHOST, 32'h1);
    step();
    bus_idle();
    step();
    n_tests++;
    if (pass[0] !== 1'b0 || fail_code[0] !== 31'd3 || done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_sticky: pass=%b fc=%0d done=%b required 0 3 1", pass[0], fail_code[0], done[0]);
    end
  endtask

  task automatic test_addr_filter();
    bring_up();
    bus_write(32'h0000_1004, 32'h1);
    step();
    mem_we    = 1'b0;
    mem_addr  = TOHOST;
    mem_wdata = 32'h1;
    step();
    bus_write(32'h8000_1000, 32'h1);
    step();
    n_tests++;
    if (done[0] !== 1'b0 || running[0] !== 1'b1 || cycle_count[0] !== 32'd3) begin
      n_fail++;
      $display("FAIL addr_filter: done=%b running=%b cyc=%0d required 0 1 3", done[0], running[0], cycle_count[0]);
    end
    bus_write(TOHOST, 32'h1);
    sb_q.push_back('{pass: 1'b1, timeout: 1'b0, fail_code: 31'd0, cycles: 32'd4, instret: 32'd0});
    step();
    bus_idle();
    check_result(0, "addr_filter_pass");
  endtask

  task automatic test_timeout();
    bring_up();
    repeat (49) step();
    n_tests++;
    if (done[1] !== 1'b0 || cycle_count[1] !== 32'd49) begin
      n_fail++;
      $display("FAIL timeout_early: done=%b cyc=%0d required 0 49", done[1], cycle_count[1]);
    end
    sb_q.push_back('{pass: 1'b0, timeout: 1'b1, fail_code: 31'd0, cycles: 32'd50, instret: 32'd0});
    step();
    check_result(1, "timeout");
  endtask

  task automatic test_tie_break();
    bring_up();
    repeat (49) step();
    bus_write(TOHOST, 32'h1);
    sb_q.push_back('{pass: 1'b1, timeout: 1'b0, fail_code: 31'd0, cycles: 32'd50, instret: 32'd0});
    step();
    bus_idle();
    check_result(1, "tie_break");
  endtask

  task automatic test_wdog_disable();
    bring_up();
    repeat (1000) step();
    n_tests++;
    if (done[2] !== 1'b0 || running[2] !== 1'b1 || cycle_count[2] !== 32'd1000) begin
      n_fail++;
      $display("FAIL wdog_disable: done=%b running=%b cyc=%0d required 0 1 1000", done[2], running[2], cycle_count[2]);
    end
  endtask

  task automatic test_async_reset();
    bring_up();
    retire_valid = 1'b1;
    repeat (3) step();
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (core_rst[0] !== 1'b1 || running[0] !== 1'b0 || done[0] !== 1'b0 ||
        cycle_count[0] !== '0 || instret_count[0] !== '0) begin
      n_fail++;
      $display("FAIL async_rst_run: rst=%b run=%b done=%b cyc=%0d ins=%0d required 1 0 0 0 0",
               core_rst[0], running[0], done[0], cycle_count[0], instret_count[0]);
    end
    bring_up();
    bus_write(TOHOST, 32'h1);
    sb_q.push_back('{pass: 1'b1, timeout: 1'b0, fail_code: 31'd0, cycles: 32'd1, instret: 32'd0});
    step();
    bus_idle();
    check_result(0, "restart_pass");
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (core_rst[0] !== 1'b1 || done[0] !== 1'b0 || pass[0] !== 1'b0 ||
        cycle_count[0] !== '0) begin
      n_fail++;
      $display("FAIL async_rst_pass: rst=%b done=%b pass=%b cyc=%0d required 1 0 0 0",
               core_rst[0], done[0], pass[0], cycle_count[0]);
    end
    bring_up();
    n_tests++;
    if (cycle_count[0] !== 32'd0 || core_rst[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clean: cyc=%0d core_rst=%b required 0 0", cycle_count[0], core_rst[0]);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_addr_filter();
    test_timeout();
    test_tie_break();
    test_wdog_disable();
    test_async_reset();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
